// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the single L1 cache port between instruction-fetch and data requesters.
// Optional hit/miss statistics outputs are present only when CACHE_ARB_STATS_EN is defined.
module cache_port_arbiter #(
    parameter int ARB_MODE     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_read,
    input  logic        d_req_write,
    input  logic [31:0] d_req_din,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        cache_is_input_valid,
    output logic [31:0] cache_addr,
    output logic        cache_mem_read,
    output logic        cache_mem_write,
    output logic [31:0] cache_din,
    input  logic        cache_is_ready,
    input  logic        cache_is_output_valid,
    input  logic        cache_is_hit,
    input  logic [31:0] cache_dout,
    output logic        busy
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [31:0] stat_i_hits,
    output logic [31:0] stat_i_misses,
    output logic [31:0] stat_d_hits,
    output logic [31:0] stat_d_misses
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RETRY = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic       PORT_I  = 1'b0;
    localparam logic       PORT_D  = 1'b1;
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_din_r;
    logic [31:0] data_r;
    logic        lat_write_r;
    logic        lat_port_r;
    logic        last_grant_r;
    logic [3:0]  starve_cnt_r;
    logic        grant_i_s;
    logic        grant_d_s;
    logic        accept_s;
    logic        active_s;
    logic        d_is_write_s;
    logic        outcome_s;

    // Arbitration: grants are only possible in IDLE with the cache ready.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == ST_IDLE && cache_is_ready) begin
            if (i_req_valid && d_req_valid) begin
                if (ARB_MODE == 32'sd0) begin
                    if (last_grant_r == PORT_D) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else begin
                    if (starve_cnt_r == LIMIT_C) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end
            end else if (i_req_valid) begin
                grant_i_s = 1'b1;
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // A simultaneous read+write request is a write; neither flag set is a read.
    always_comb begin
        d_is_write_s = 1'b0;
        case ({d_req_read, d_req_write})
            2'b01:   d_is_write_s = 1'b1;
            2'b11:   d_is_write_s = 1'b1;
            2'b10:   d_is_write_s = 1'b0;
            default: d_is_write_s = 1'b0;
        endcase
    end

    assign accept_s  = grant_i_s | grant_d_s;
    assign outcome_s = (state_r == ST_WAIT) && cache_is_output_valid;

    // Next-state logic for the cache handshake sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (cache_is_output_valid) begin
                    state_nxt_s = cache_is_hit ? ST_RESP : ST_RETRY;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RETRY: begin
                if (cache_is_ready) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_RETRY;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, request latch and hit-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            lat_addr_r   <= 32'h0;
            lat_din_r    <= 32'h0;
            lat_write_r  <= 1'b0;
            lat_port_r   <= PORT_I;
            last_grant_r <= PORT_I;
            data_r       <= 32'h0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                lat_port_r   <= grant_d_s ? PORT_D : PORT_I;
                last_grant_r <= grant_d_s ? PORT_D : PORT_I;
                if (grant_d_s) begin
                    lat_addr_r  <= d_req_addr;
                    lat_write_r <= d_is_write_s;
                    lat_din_r   <= d_is_write_s ? d_req_din : 32'h0;
                end else begin
                    lat_addr_r  <= i_req_addr;
                    lat_write_r <= 1'b0;
                    lat_din_r   <= 32'h0;
                end
            end
            if (outcome_s && cache_is_hit) begin
                data_r <= lat_write_r ? 32'h0 : cache_dout;
            end
        end
    end

    // I starvation counter: counts D wins while I waits, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_i_s) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_d_s && i_req_valid && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign active_s             = (state_r == ST_ISSUE) || (state_r == ST_WAIT) || (state_r == ST_RETRY);
    assign cache_is_input_valid = (state_r == ST_ISSUE);
    assign cache_addr           = active_s ? lat_addr_r : 32'h0;
    assign cache_din            = active_s ? lat_din_r : 32'h0;
    assign cache_mem_read       = active_s & ~lat_write_r;
    assign cache_mem_write      = active_s & lat_write_r;
    assign i_req_ready          = grant_i_s;
    assign d_req_ready          = grant_d_s;
    assign i_resp_valid         = (state_r == ST_RESP) && (lat_port_r == PORT_I);
    assign d_resp_valid         = (state_r == ST_RESP) && (lat_port_r == PORT_D);
    assign i_resp_data          = i_resp_valid ? data_r : 32'h0;
    assign d_resp_data          = d_resp_valid ? data_r : 32'h0;
    assign busy                 = (state_r != ST_IDLE);

`ifdef CACHE_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic first_r;

    // Per-transaction hit/miss statistics; only the first cache outcome is counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_r       <= 1'b0;
            stat_i_hits   <= 32'h0;
            stat_i_misses <= 32'h0;
            stat_d_hits   <= 32'h0;
            stat_d_misses <= 32'h0;
        end else if (accept_s) begin
            first_r <= 1'b1;
        end else if (outcome_s && first_r) begin
            first_r <= 1'b0;
            case ({lat_port_r, cache_is_hit})
                2'b01:   stat_i_hits   <= sat_inc(stat_i_hits);
                2'b00:   stat_i_misses <= sat_inc(stat_i_misses);
                2'b11:   stat_d_hits   <= sat_inc(stat_d_hits);
                default: stat_d_misses <= sat_inc(stat_d_misses);
            endcase
        end else begin
            first_r <= first_r;
        end
    end
`endif

endmodule
